// File: rtl/rep_2_if.sv
// Bundle for rep_2: five operand bits in, equality matrix and stats out.
// master drives a..e and reads results; slave is the rep_2 side.
interface rep_2_if;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        e;
    logic [24:0] out;
    logic [24:0] out_q;
    logic        all_eq;
    logic [4:0]  match_cnt;

    modport master (
        output a, b, c, d, e,
        input  out, out_q, all_eq, match_cnt
    );

    modport slave (
        input  a, b, c, d, e,
        output out, out_q, all_eq, match_cnt
    );
endinterface

// File: rtl/rep_2.sv
// rep_2: 5x5 pairwise bit-equality (XNOR) matrix with registered copy,
// all-equal flag and optional popcount stage (macro REP2_STATS_EN).
// Ports: clk, rst_n (async active-low), bus (rep_2_if.slave):
//   a..e in; out (comb), out_q/all_eq (1 cycle), match_cnt (2 cycles).
module rep_2 (
    input  logic  clk,
    input  logic  rst_n,
    rep_2_if.slave bus
);
    logic [4:0]  v;
    logic [24:0] mat;
    logic [24:0] mat_d, mat_q;
    logic        all_eq_d, all_eq_q;

    assign v = {bus.a, bus.b, bus.c, bus.d, bus.e};

    // Row i (MSB first) is v_i replicated, XNORed against the whole vector.
    assign mat = ~({{5{bus.a}}, {5{bus.b}}, {5{bus.c}},
                    {5{bus.d}}, {5{bus.e}}} ^ {5{v}});

    assign mat_d    = mat;
    assign all_eq_d = &mat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q    <= '0;
            all_eq_q <= 1'b0;
        end else begin
            mat_q    <= mat_d;
            all_eq_q <= all_eq_d;
        end
    end

    assign bus.out    = mat;
    assign bus.out_q  = mat_q;
    assign bus.all_eq = all_eq_q;

`ifdef REP2_STATS_EN
    logic [4:0] cnt_d, cnt_q;

    // Popcount of the registered matrix, registered again.
    always_comb begin
        cnt_d = '0;
        for (int k = 0; k < 25; k++) begin
            cnt_d = cnt_d + {4'b0, mat_q[k]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = 5'd0;
`endif
endmodule

// File: tb/tb_rep_2.sv
// Directed self-checking bench for rep_2.
// Runs with or without REP2_STATS_EN.
module tb_rep_2;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rep_2_if bus ();

    rep_2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] model(input logic [4:0] v);
        logic [24:0] r;
        r = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                r[24-5*i-j] = (v[4-i] == v[4-j]);
        return r;
    endfunction

    function automatic int pop(input logic [24:0] m);
        int n;
        n = 0;
        for (int k = 0; k < 25; k++) n += int'(m[k]);
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] cnt_exp(input logic [24:0] prev_q);
`ifdef REP2_STATS_EN
        return 5'(pop(prev_q));
`else
        return 5'(pop(prev_q) * 0);
`endif
    endfunction

    task automatic drive(input logic [4:0] v);
        {bus.a, bus.b, bus.c, bus.d, bus.e} = v;
    endtask

    initial begin
        logic [24:0] prev_q;
        logic [24:0] m;
        logic        sym;
        int          p;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(5'b00000);
        #12;
        check("rst_out_q", 32'(bus.out_q), 32'h0);
        check("rst_all_eq", 32'(bus.all_eq), 32'h0);
        check("rst_cnt", 32'(bus.match_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 01101
        drive(5'b01101);
        #1;
        check("v01101_out", 32'(bus.out), 32'h126B64D);
        @(posedge clk); #1;
        check("v01101_out_q", 32'(bus.out_q), 32'h126B64D);
        check("v01101_all_eq", 32'(bus.all_eq), 32'h0);
        @(posedge clk); #1;
        check("v01101_cnt", 32'(bus.match_cnt), 32'(cnt_exp(25'h126B64D)));

        // 11111 then 00000
        drive(5'b11111);
        #1;
        check("v11111_out", 32'(bus.out), 32'h1FFFFFF);
        @(posedge clk); #1;
        check("v11111_all_eq", 32'(bus.all_eq), 32'h1);
        drive(5'b00000);
        #1;
        check("v00000_out", 32'(bus.out), 32'h1FFFFFF);
        @(posedge clk); #1;
        check("v00000_out_q", 32'(bus.out_q), 32'h1FFFFFF);
        check("v00000_all_eq", 32'(bus.all_eq), 32'h1);
        check("v00000_cnt", 32'(bus.match_cnt), 32'(cnt_exp(25'h1FFFFFF)));

        // 10101 alternating pattern
        drive(5'b10101);
        #1;
        check("v10101_out", 32'(bus.out), 32'h1555555);
        @(posedge clk); #1;
        check("v10101_all_eq", 32'(bus.all_eq), 32'h0);
        prev_q = 25'h1555555;

        // Exhaustive sweep, plus 01001 / 10001 covered inside it.
        for (int i = 0; i < 32; i++) begin
            drive(5'(i));
            #1;
            m = model(5'(i));
            check("sweep_out", 32'(bus.out), 32'(m));
            check("sweep_diag", 32'({bus.out[24], bus.out[18],
                  bus.out[12], bus.out[6], bus.out[0]}), 32'h1F);
            sym = 1'b1;
            for (int r = 0; r < 5; r++)
                for (int s = 0; s < 5; s++)
                    if (bus.out[24-5*r-s] !== bus.out[24-5*s-r]) sym = 1'b0;
            check("sweep_sym", 32'(sym), 32'h1);
            p = pop(bus.out);
            check("sweep_pop", 32'(p == 5 || p == 13 || p == 17 || p == 25),
                  32'h1);
            @(posedge clk); #1;
            check("sweep_out_q", 32'(bus.out_q), 32'(m));
            check("sweep_all_eq", 32'(bus.all_eq),
                  32'(i == 0 || i == 31));
            check("sweep_cnt", 32'(bus.match_cnt), 32'(cnt_exp(prev_q)));
            prev_q = m;
        end

        // Async reset between edges with 10110 applied.
        drive(5'b10110);
        @(posedge clk); #1;
        check("v10110_out_q", 32'(bus.out_q), 32'h164DAC9);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_q", 32'(bus.out_q), 32'h0);
        check("arst_all_eq", 32'(bus.all_eq), 32'h0);
        check("arst_cnt", 32'(bus.match_cnt), 32'h0);
        check("arst_out", 32'(bus.out), 32'h164DAC9);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_out_q", 32'(bus.out_q), 32'h164DAC9);
        check("rel_cnt0", 32'(bus.match_cnt), 32'h0);
        @(posedge clk); #1;
        check("rel_cnt", 32'(bus.match_cnt), 32'(cnt_exp(25'h164DAC9)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
